// File: rtl/axi_frame_writer.sv
// rtl/axi_frame_writer.sv - frames an untimed sample stream into tlast-delimited bursts for a downstream FIFO
// Two-entry input skid buffer, registered output stage, frame FSM gated by fifo_almost_full at frame start.
module axi_frame_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    input  logic [CNT_WIDTH-1:0]  frame_len,
    input  logic                  fifo_almost_full,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
    logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
    logic [1:0]            occ_q, occ_d;
    logic                  s_tready_q, s_tready_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tlast_q, m_tlast_d;
    logic [0:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;

    logic accept;
    logic allow;
    logic load;
    logic load_last;

    always_comb begin
        accept = s_axis_tvalid && s_tready_q;
        // almost_full only gates the first beat of a frame; a started frame always completes
        allow  = (state_q == ST_SEND) || !fifo_almost_full;
        load   = (occ_q != 2'd0) && (!m_tvalid_q || m_axis_tready) && allow;

        skid0_d = skid0_q;
        skid1_d = skid1_q;
        occ_d   = occ_q;
        case ({accept, load})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    skid0_d = s_axis_tdata;
                end else begin
                    skid1_d = s_axis_tdata;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                skid0_d = skid1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    skid0_d = s_axis_tdata;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = s_axis_tdata;
                end
            end
            default: ;
        endcase
        s_tready_d = (occ_d < 2'd2);

        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        load_last  = 1'b0;
        if (load) begin
            if (state_q == ST_IDLE) begin
                len_d      = frame_len;
                beat_cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                load_last  = (frame_len == '0);
                state_d    = load_last ? ST_IDLE : ST_SEND;
            end else begin
                load_last  = (beat_cnt_q == len_q);
                // clear on the final beat so the counter never runs past len_q
                beat_cnt_d = load_last ? '0 : beat_cnt_q + 1'b1;
                state_d    = load_last ? ST_IDLE : ST_SEND;
            end
        end

        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        if (load) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = skid0_q;
            m_tlast_d  = load_last;
        end else if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end

        frame_cnt_d = frame_cnt_q;
        if (m_tvalid_q && m_axis_tready && m_tlast_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            skid0_q     <= '0;
            skid1_q     <= '0;
            occ_q       <= 2'd0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tlast_q   <= 1'b0;
            state_q     <= ST_IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            frame_cnt_q <= 16'd0;
        end else begin
            skid0_q     <= skid0_d;
            skid1_q     <= skid1_d;
            occ_q       <= occ_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tdata_q   <= m_tdata_d;
            m_tlast_q   <= m_tlast_d;
            state_q     <= state_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_axis_tready = s_tready_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tlast  = m_tlast_q;
    assign busy          = (state_q == ST_SEND);
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axi_frame_writer.sv
// tb/tb_axi_frame_writer.sv - scoreboard bench for axi_frame_writer
module tb_axi_frame_writer;

    logic        clk = 1'b0;
    logic        sync_reset = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tready;
    logic [7:0]  frame_len = 8'd3;
    logic        fifo_almost_full = 1'b0;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        busy;
    logic [15:0] frame_cnt;

    axi_frame_writer #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk              (clk),
        .sync_reset       (sync_reset),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tready    (s_axis_tready),
        .frame_len        (frame_len),
        .fifo_almost_full (fifo_almost_full),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tready    (m_axis_tready),
        .busy             (busy),
        .frame_cnt        (frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q[$];
    int          pos = 0;
    int          cur_len = 0;
    int          exp_frames = 0;
    int          tready_mode = 0;
    bit          snd_done = 1'b1;
    bit          hold_v = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // Output monitor: every handshake is checked against the scoreboard and a frame model
    always @(negedge clk) begin
        if (sync_reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata, hold_d);
                check("hold_last", m_axis_tlast, hold_l);
            end
            hold_v = m_axis_tvalid && !m_axis_tready;
            hold_d = m_axis_tdata;
            hold_l = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                check("sb_nonempty", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) check("data", m_axis_tdata, sb_q.pop_front());
                if (pos == 0) cur_len = int'(frame_len);
                check("tlast", m_axis_tlast, (pos == cur_len));
                if (pos == cur_len) begin
                    pos = 0;
                    exp_frames++;
                end else begin
                    pos++;
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        while (!s_axis_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) begin
            check("accept_timeout", 0, 1);
            s_axis_tvalid = 1'b0;
        end else begin
            sb_q.push_back(d);
            @(negedge clk);
            s_axis_tvalid = 1'b0;
        end
    endtask

    task automatic send_n(input int n, input logic [31:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(base + 32'(i));
        end
        snd_done = 1'b1;
    endtask

    task automatic wait_pos(input int target);
        int n = 0;
        while (pos != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_pos", pos, target);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!snd_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("sender_done", snd_done, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("drain", sb_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        sync_reset = 1'b0;
        @(negedge clk);
        check("s_tready_after_rst", s_axis_tready, 1);

        // Test 1: continuous 4-beat frames, latency of the first beat
        frame_len = 8'd3;
        send_beat(32'd0);
        check("lat_1clk_tvalid", m_axis_tvalid, 0);
        send_beat(32'd1);
        check("lat_2clk_tvalid", m_axis_tvalid, 1);
        check("lat_2clk_tdata", m_axis_tdata, 0);
        for (int i = 2; i < 12; i++) send_beat(32'(i));
        drain();
        check("t1_frame_cnt", frame_cnt, 3);

        // Test 2: almost_full blocks the frame start; skid fills to two
        fifo_almost_full = 1'b1;
        snd_done = 1'b0;
        fork
            send_n(8, 32'd100, 1'b0);
        join_none
        repeat (10) @(negedge clk);
        check("af_no_tvalid", m_axis_tvalid, 0);
        check("af_s_tready", s_axis_tready, 0);
        fifo_almost_full = 1'b0;
        @(negedge clk);
        check("af_drop_tvalid", m_axis_tvalid, 1);
        check("af_drop_tdata", m_axis_tdata, 100);
        wait_done();
        drain();
        check("t2_frame_cnt", frame_cnt, 16'(exp_frames));

        // Test 3: almost_full rising mid-frame does not stop the frame
        frame_len = 8'd7;
        snd_done = 1'b0;
        fork
            send_n(16, 32'd200, 1'b0);
        join_none
        wait_pos(2);
        fifo_almost_full = 1'b1;
        check("mid_busy", busy, 1);
        begin
            int n = 0;
            while (exp_frames != 6 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("t3_frame_done", exp_frames, 6);
        repeat (4) @(negedge clk);
        check("af_hold_next_frame", m_axis_tvalid, 0);
        check("af_idle_busy", busy, 0);
        fifo_almost_full = 1'b0;
        wait_done();
        drain();
        check("t3_frame_cnt", frame_cnt, 16'(exp_frames));

        // Test 4: toggling m_axis_tready, random input gaps
        frame_len = 8'd3;
        tready_mode = 1;
        snd_done = 1'b0;
        fork
            send_n(20, 32'd300, 1'b1);
        join_none
        wait_done();
        drain();
        tready_mode = 0;
        repeat (2) @(negedge clk);
        check("t4_frame_cnt", frame_cnt, 16'(exp_frames));

        // Test 5: frame_len change mid-frame, then single-beat frames
        frame_len = 8'd3;
        snd_done = 1'b0;
        fork
            send_n(12, 32'd500, 1'b0);
        join_none
        wait_pos(2);
        frame_len = 8'd7;
        wait_done();
        drain();
        frame_len = 8'd0;
        for (int i = 0; i < 5; i++) send_beat(32'd600 + 32'(i));
        drain();
        check("t5_frame_cnt", frame_cnt, 16'(exp_frames));

        // Test 6: reset in the middle of a 4-beat frame
        frame_len = 8'd3;
        snd_done = 1'b0;
        fork
            send_n(4, 32'd700, 1'b0);
        join_none
        wait_pos(2);
        wait_done();
        sync_reset = 1'b1;
        @(negedge clk);
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_tlast", m_axis_tlast, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        sync_reset = 1'b0;
        sb_q.delete();
        pos = 0;
        exp_frames = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_beat(32'd800 + 32'(i));
        drain();
        check("t6_frame_cnt", frame_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
